// File: rtl/my_pkg.sv
// Shared pipeline-control types: ID/EX control groups, their NOP encoding and hazard FSM states.
package my_pkg;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } WB_ctrl;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } M_ctrl;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
  } EX_ctrl;

  typedef struct packed {
    WB_ctrl wb;
    M_ctrl  m;
    EX_ctrl ex;
  } idex_ctrl_t;

  // A bubble is an all-zero control word: no write-back, no memory access, no branch.
  localparam idex_ctrl_t NOP_CTRL = '0;

  typedef logic [1:0] hz_state_t;
  localparam hz_state_t RUN        = 2'd0;
  localparam hz_state_t LOAD_STALL = 2'd1;
  localparam hz_state_t MEM_WAIT   = 2'd2;
  localparam hz_state_t FLUSH      = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. HAZARD_PERF_EN adds the stall/flush counters.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_MemRead, mem_cs, mem_take, mem_ready;
  logic        pc_write, ifid_write, idex_bubble;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic        pipe_hold, mem_req, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_MemRead, mem_cs, mem_take, mem_ready,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
    input  pipe_hold, mem_req, mem_err
`ifdef HAZARD_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_MemRead, mem_cs, mem_take, mem_ready,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
    output pipe_hold, mem_req, mem_err
`ifdef HAZARD_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use compare: the load in EX writes a register the ID instruction reads (x0 never hazards).
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);
  assign load_use = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, data-memory wait with timeout, branch flush.
// Define HAZARD_PERF_EN to add stall_cnt/flush_cnt performance counters.
module hazard_ctrl
  import my_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  hz_state_t  state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;
  logic       load_use;
  logic       pc_write, ifid_write, idex_bubble;
  logic       ifid_flush, idex_flush, exmem_flush, pipe_hold, mem_req;

  hazard_detect u_detect (
    .ex_mem_read (hz.ex_MemRead),
    .ex_rd       (hz.ex_rd),
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .load_use    (load_use)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    mem_req     = 1'b0;
    case (state_q)
      RUN, LOAD_STALL: begin
        mem_req = !hz.mem_cs;
        // Flush beats memory wait beats load-use; the flush also drops any pending bubble.
        if (hz.mem_take) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          state_d     = FLUSH;
        end else if (!hz.mem_cs && !hz.mem_ready) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          wcnt_d     = 8'd1;
          state_d    = MEM_WAIT;
        end else if (state_q == RUN && load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = LOAD_STALL;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (hz.mem_ready) begin
          state_d = RUN;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          if (wcnt_q == TMO) begin
            err_d   = 1'b1;
            state_d = RUN;
          end else begin
            wcnt_d = sat_inc8(wcnt_q);
          end
        end
      end
      FLUSH: begin
        // Second IF/ID flush kills the instruction fetched from the stale PC.
        ifid_flush = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
    if (state_d == RUN) wcnt_d = 8'd0;
    // Outputs must show reset values while rst is high, regardless of inputs.
    if (rst) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pipe_hold   = 1'b0;
      mem_req     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.idex_bubble = idex_bubble;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.pipe_hold   = pipe_hold;
  assign hz.mem_req     = mem_req;
  assign hz.mem_err     = err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = pc_write ? stall_cnt_q : stall_cnt_q + 32'd1;
    flush_cnt_d = (state_d == FLUSH && state_q != FLUSH) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised + directed bench for hazard_ctrl against an event-level behavioural model.
module tb_hazard_ctrl;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flags describing what the pipeline is currently doing, not a state encoding.
  bit m_waiting, m_tail, m_just_bubbled, m_err;
  int m_waited;
  int unsigned m_stalls, m_flushes;

  function automatic logic [8:0] dut_vec();
    return {hif.pc_write, hif.ifid_write, hif.idex_bubble, hif.ifid_flush, hif.idex_flush,
            hif.exmem_flush, hif.pipe_hold, hif.mem_req, hif.mem_err};
  endfunction

  always @(negedge clk) begin
    logic pw, iw, bub, f1, f2, f3, hold, req, hazard;
    pw = 1; iw = 1; bub = 0; f1 = 0; f2 = 0; f3 = 0; hold = 0; req = 0;
    if (rst) begin
      m_waiting = 0; m_tail = 0; m_just_bubbled = 0; m_err = 0;
      m_waited = 0; m_stalls = 0; m_flushes = 0;
      chk("model_vec", 64'(dut_vec()), 64'(9'b110000000));
    end else begin
      logic err_now;
      err_now = m_err;
      if (m_tail) begin
        f1 = 1; m_tail = 0;
      end else if (m_waiting) begin
        req = 1;
        if (hif.mem_ready) m_waiting = 0;
        else begin
          hold = 1; pw = 0; iw = 0;
          if (m_waited == TMO) begin m_err = 1; m_waiting = 0; end
          else m_waited++;
        end
      end else begin
        req = !hif.mem_cs;
        hazard = hif.ex_MemRead && hif.ex_rd != 0 &&
                 (hif.ex_rd == hif.id_rs1 || hif.ex_rd == hif.id_rs2) && !m_just_bubbled;
        m_just_bubbled = 0;
        if (hif.mem_take) begin
          f1 = 1; f2 = 1; f3 = 1; m_tail = 1;
        end else if (!hif.mem_cs && !hif.mem_ready) begin
          hold = 1; pw = 0; iw = 0; m_waiting = 1; m_waited = 1;
        end else if (hazard) begin
          pw = 0; iw = 0; bub = 1; m_just_bubbled = 1;
        end
      end
      chk("model_vec", 64'(dut_vec()), 64'({pw, iw, bub, f1, f2, f3, hold, req, err_now}));
`ifdef HAZARD_PERF_EN
      chk("model_stall_cnt", 64'(hif.stall_cnt), 64'(m_stalls));
      chk("model_flush_cnt", 64'(hif.flush_cnt), 64'(m_flushes));
`endif
      if (!pw) m_stalls++;
      if (f3)  m_flushes++;
    end
  end

  task automatic cyc(input logic mr, input logic [4:0] rd, r1, r2,
                     input logic cs, tk, rdy);
    @(posedge clk); #1;
    rst = 0;
    hif.ex_MemRead = mr; hif.ex_rd = rd; hif.id_rs1 = r1; hif.id_rs2 = r2;
    hif.mem_cs = cs; hif.mem_take = tk; hif.mem_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    // Hazard and memory-stall inputs active during reset: outputs must ignore them.
    hif.ex_MemRead = 1; hif.ex_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_rs2 = 5'd0;
    hif.mem_cs = 0; hif.mem_take = 0; hif.mem_ready = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc_write", 64'(hif.pc_write), 1);
    chk("rst_bubble",   64'(hif.idex_bubble), 0);
    chk("rst_hold",     64'(hif.pipe_hold), 0);
    chk("rst_mem_req",  64'(hif.mem_req), 0);

    // Load-use on rs2: one bubble, then enables return.
    cyc(1, 5, 0, 5, 1, 0, 0);
    chk("lu_pc_write", 64'(hif.pc_write), 0);
    chk("lu_bubble",   64'(hif.idex_bubble), 1);
    cyc(1, 5, 0, 5, 1, 0, 0);
    chk("lu2_pc_write", 64'(hif.pc_write), 1);
    chk("lu2_bubble",   64'(hif.idex_bubble), 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lu3_pc_write", 64'(hif.pc_write), 1);

    // x0 destination never stalls.
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("x0_pc_write", 64'(hif.pc_write), 1);
    chk("x0_bubble",   64'(hif.idex_bubble), 0);

    // Ready low three cycles then high.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("mw_hold", 64'(hif.pipe_hold), 1);
      chk("mw_req",  64'(hif.mem_req), 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("mw_release_hold", 64'(hif.pipe_hold), 0);
    chk("mw_release_pc",   64'(hif.pc_write), 1);
    chk("mw_release_err",  64'(hif.mem_err), 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("mw_idle_req", 64'(hif.mem_req), 0);

    // Timeout after TMO wait cycles; error is sticky.
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("to_start_hold", 64'(hif.pipe_hold), 1);
    for (int i = 0; i < TMO; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("to_wait_hold", 64'(hif.pipe_hold), 1);
      chk("to_wait_err",  64'(hif.mem_err), 0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("to_exit_hold", 64'(hif.pipe_hold), 0);
    chk("to_exit_err",  64'(hif.mem_err), 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("to_sticky_err", 64'(hif.mem_err), 1);

    // Taken branch coincident with load-use: flush wins, no bubble.
    cyc(1, 3, 3, 0, 1, 1, 0);
    chk("fl_flushes", 64'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush}), 3'b111);
    chk("fl_bubble",  64'(hif.idex_bubble), 0);
    chk("fl_pc",      64'(hif.pc_write), 1);
    cyc(1, 3, 3, 0, 1, 0, 0);
    chk("fl_tail", 64'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.idex_bubble}), 4'b1000);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("fl_done", 64'({hif.ifid_flush, hif.idex_flush, hif.exmem_flush}), 3'b000);

    // Reset mid-MEM_WAIT aborts immediately.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rw_in_wait", 64'(hif.pipe_hold), 1);
    #2 rst = 1;
    #1;
    chk("rw_vec", 64'(dut_vec()), 64'(9'b110000000));
`ifdef HAZARD_PERF_EN
    chk("rw_stall_cnt", 64'(hif.stall_cnt), 0);
    chk("rw_flush_cnt", 64'(hif.flush_cnt), 0);
`endif
    @(negedge clk);
    cyc(1, 7, 7, 0, 1, 0, 0);
    chk("rw_first_run_bubble", 64'(hif.idex_bubble), 1);

    // Randomised traffic, checked every cycle by the model process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst            = ($urandom_range(0, 199) == 0);
      hif.ex_MemRead = ($urandom_range(0, 1) == 1);
      hif.ex_rd      = 5'($urandom_range(0, 3));
      hif.id_rs1     = 5'($urandom_range(0, 3));
      hif.id_rs2     = 5'($urandom_range(0, 3));
      hif.mem_cs     = ($urandom_range(0, 3) != 0);
      hif.mem_take   = ($urandom_range(0, 11) == 0);
      hif.mem_ready  = ($urandom_range(0, 4) < 2);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
